// File: rtl/mont_exp_arbiter.sv
// Round-robin arbiter sharing one montgomery_exp core between NREQ requesters.
// Optional watchdog abort is compiled in with `define MONT_ARB_TIMEOUT_EN.
module mont_exp_arbiter #(
    parameter int unsigned NREQ           = 2,
    parameter int unsigned WIDTH          = 1024,
    parameter int unsigned EWIDTH         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NREQ-1:0]                       req,
    input  logic [NREQ*WIDTH-1:0]                 req_msg,
    input  logic [NREQ*EWIDTH-1:0]                req_exp,
    input  logic [NREQ*WIDTH-1:0]                 req_n,
    input  logic [NREQ*WIDTH-1:0]                 req_rmodn,
    input  logic [NREQ*WIDTH-1:0]                 req_r2modn,
    output logic [NREQ-1:0]                       rsp_valid,
    output logic [WIDTH-1:0]                      rsp_result,
    output logic                                  rsp_err,
    output logic                                  busy,
    output logic [(NREQ > 1 ? $clog2(NREQ) : 1)-1:0] owner,
    output logic                                  core_start,
    output logic [WIDTH-1:0]                      core_msg,
    output logic [EWIDTH-1:0]                     core_exp,
    output logic [WIDTH-1:0]                      core_n,
    output logic [WIDTH-1:0]                      core_rmodn,
    output logic [WIDTH-1:0]                      core_r2modn,
    output logic                                  core_abort,
    input  logic [WIDTH-1:0]                      core_result,
    input  logic                                  core_done
);

    localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_GUARD = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [OW-1:0]    ptr_q, ptr_d;
    logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             busy_q, busy_d;
    logic             core_start_q, core_start_d;

    logic             grant_found;
    logic [OW-1:0]    grant_idx;
    int unsigned      rr_idx;

`ifdef MONT_ARB_TIMEOUT_EN
    logic [31:0]      cnt_q, cnt_d;
    logic             rsp_err_q, rsp_err_d;
    logic             core_abort_q, core_abort_d;
`endif

    // First requester searching upward from the slot after the last grant.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        rr_idx      = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            rr_idx = 32'(ptr_q) + k;
            if (rr_idx >= NREQ) begin
                rr_idx = rr_idx - NREQ;
            end
            if (!grant_found && |(req & (NREQ'(1) << rr_idx))) begin
                grant_found = 1'b1;
                grant_idx   = OW'(rr_idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        ptr_d        = ptr_q;
        rsp_result_d = rsp_result_q;
`ifdef MONT_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        rsp_err_d    = 1'b0;
        core_abort_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    state_d = S_START;
                    owner_d = grant_idx;
                    ptr_d   = grant_idx;
`ifdef MONT_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_START: state_d = S_GUARD;
            // core_done may still be high from the previous operation here.
            S_GUARD: begin
                state_d = S_WAIT;
`ifdef MONT_ARB_TIMEOUT_EN
                cnt_d   = cnt_q + 32'd1;
`endif
            end
            S_WAIT: begin
                if (core_done) begin
                    rsp_result_d = core_result;
                    state_d      = S_RESP;
                end
`ifdef MONT_ARB_TIMEOUT_EN
                else if (cnt_q >= TIMEOUT_CYCLES) begin
                    rsp_result_d = '0;
                    rsp_err_d    = 1'b1;
                    core_abort_d = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
`endif
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d       = (state_d != S_IDLE);
        core_start_d = (state_d == S_START);
        rsp_valid_d  = (state_d == S_RESP) ? (NREQ'(1) << owner_d) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_q      <= '0;
            ptr_q        <= OW'(NREQ - 1);
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            busy_q       <= 1'b0;
            core_start_q <= 1'b0;
`ifdef MONT_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            rsp_err_q    <= 1'b0;
            core_abort_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            busy_q       <= busy_d;
            core_start_q <= core_start_d;
`ifdef MONT_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            rsp_err_q    <= rsp_err_d;
            core_abort_q <= core_abort_d;
`endif
        end
    end

    // Operands follow the owner register, so they hold from START through RESP.
    always_comb begin
        core_msg    = req_msg[32'(owner_q)*WIDTH +: WIDTH];
        core_exp    = req_exp[32'(owner_q)*EWIDTH +: EWIDTH];
        core_n      = req_n[32'(owner_q)*WIDTH +: WIDTH];
        core_rmodn  = req_rmodn[32'(owner_q)*WIDTH +: WIDTH];
        core_r2modn = req_r2modn[32'(owner_q)*WIDTH +: WIDTH];
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign busy       = busy_q;
    assign owner      = owner_q;
    assign core_start = core_start_q;
`ifdef MONT_ARB_TIMEOUT_EN
    assign rsp_err    = rsp_err_q;
    assign core_abort = core_abort_q;
`else
    assign rsp_err    = 1'b0;
    assign core_abort = 1'b0;
`endif

endmodule

// File: tb/tb_mont_exp_arbiter.sv
// Bench for mont_exp_arbiter: transaction-level expectation model, a simple
// modexp core model, and directed scenarios with hand-computed results.
module tb_mont_exp_arbiter;

    localparam int unsigned W   = 1024;
    localparam int unsigned EW  = 16;
    localparam int          LAT = 40;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        req;
    logic [2*W-1:0]    req_msg, req_n, req_rmodn, req_r2modn;
    logic [2*EW-1:0]   req_exp;
    logic [1:0]        rsp_valid;
    logic [W-1:0]      rsp_result;
    logic              rsp_err, busy, core_start, core_abort, core_done;
    logic [0:0]        owner;
    logic [W-1:0]      core_msg, core_n, core_rmodn, core_r2modn, core_result;
    logic [EW-1:0]     core_exp;

    int errors = 0;
    int checks = 0;

    mont_exp_arbiter dut (
        .clk(clk), .reset(reset), .req(req),
        .req_msg(req_msg), .req_exp(req_exp), .req_n(req_n),
        .req_rmodn(req_rmodn), .req_r2modn(req_r2modn),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
        .busy(busy), .owner(owner), .core_start(core_start),
        .core_msg(core_msg), .core_exp(core_exp), .core_n(core_n),
        .core_rmodn(core_rmodn), .core_r2modn(core_r2modn),
        .core_abort(core_abort), .core_result(core_result), .core_done(core_done)
    );

    always #5 clk = ~clk;

    function automatic longint unsigned modexp(longint unsigned b, longint unsigned e,
                                               longint unsigned m);
        longint unsigned r = 1;
        longint unsigned x = b % m;
        while (e != 0) begin
            if (e[0]) r = (r * x) % m;
            x = (x * x) % m;
            e = e >> 1;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Core model: done stays high after completion until one cycle after the next start.
    bit              c_run, c_st;
    int              c_cnt;
    longint unsigned c_m, c_e, c_n;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            c_run = 0; c_cnt = 0; core_done = 1'b0; core_result = '0;
        end else begin
            c_st = core_start;
            c_m  = core_msg[63:0];
            c_e  = 64'(core_exp);
            c_n  = core_n[63:0];
            #1;
            if (c_st) begin
                c_run = 1; c_cnt = 1;
            end else if (c_run) begin
                c_cnt++;
                if (c_cnt == 2) core_done = 1'b0;
                if (c_cnt == LAT) begin
                    core_done   = 1'b1;
                    core_result = W'(modexp(c_m, c_e, c_n));
                    c_run       = 0;
                end
            end
        end
    end

    // Expectation model: grant, a start cycle, one ignored cycle, then wait for done.
    bit       m_busy, m_resp;
    int       m_age, m_owner, m_ptr;
    logic [W-1:0] m_res;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_resp = 0; m_age = 0; m_owner = 0; m_ptr = 1; m_res = '0;
        end else if (m_resp) begin
            m_busy = 0; m_resp = 0;
        end else if (!m_busy) begin
            for (int k = 1; k <= 2; k++) begin
                int i;
                i = (m_ptr + k) % 2;
                if (!m_busy && req[i]) begin
                    m_busy = 1; m_age = 1; m_owner = i; m_ptr = i;
                end
            end
        end else begin
            if (m_age >= 3 && core_done) begin
                m_res  = core_result;
                m_resp = 1;
            end
            m_age++;
        end
    end

    int log_owner[$];
    longint unsigned log_res[$];

    always @(negedge clk) begin
        chk("rsp_valid", W'(rsp_valid), m_resp ? W'(2'b01 << m_owner) : '0);
        chk("rsp_result", rsp_result, m_res);
        chk("busy", W'(busy), W'(m_busy));
        chk("owner", W'(owner), W'(m_owner));
        chk("core_start", W'(core_start), W'(m_busy && !m_resp && m_age == 1));
        chk("rsp_err", W'(rsp_err), '0);
        chk("core_abort", W'(core_abort), '0);
        if (m_busy) begin
            chk("core_msg", core_msg, req_msg[m_owner*W +: W]);
            chk("core_exp", W'(core_exp), W'(req_exp[m_owner*EW +: EW]));
            chk("core_n", core_n, req_n[m_owner*W +: W]);
            chk("core_rmodn", core_rmodn, req_rmodn[m_owner*W +: W]);
            chk("core_r2modn", core_r2modn, req_r2modn[m_owner*W +: W]);
        end
        if (rsp_valid != 2'b00) begin
            log_owner.push_back(rsp_valid == 2'b01 ? 0 : (rsp_valid == 2'b10 ? 1 : 9));
            log_res.push_back(rsp_result[63:0]);
        end
    end

    task automatic set_ops(input int i, input longint unsigned msg, input longint unsigned e,
                           input longint unsigned n);
        req_msg[i*W +: W]    = W'(msg);
        req_exp[i*EW +: EW]  = EW'(e);
        req_n[i*W +: W]      = W'(n);
        req_rmodn[i*W +: W]  = W'(n + 64'd17 + 64'(i));
        req_r2modn[i*W +: W] = W'(n * 64'd3 + 64'(i));
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b1; req = 2'b00;
        @(posedge clk); #2;
        reset = 1'b0;
    endtask

    // Waits until the response log reaches n entries, then drops req in the IDLE cycle.
    task automatic wait_log(input int n);
        int budget = 400;
        while (log_owner.size() < n && budget > 0) begin
            @(posedge clk); #2;
            budget--;
        end
        checks++;
        if (log_owner.size() < n) begin
            errors++;
            $display("FAIL wait_rsp: got %0d responses expected %0d", log_owner.size(), n);
        end
        req = 2'b00;
    endtask

    task automatic expect_log(input string name, input int idx, input int own,
                              input longint unsigned res);
        if (idx < log_owner.size()) begin
            chk({name, "_owner"}, W'(log_owner[idx]), W'(own));
            chk({name, "_result"}, W'(log_res[idx]), W'(res));
        end else begin
            checks++; errors++;
            $display("FAIL %s: got no response expected entry %0d", name, idx);
        end
    endtask

    initial begin
        int n0;
        reset = 1'b0; req = 2'b00;
        req_msg = '0; req_exp = '0; req_n = '0; req_rmodn = '0; req_r2modn = '0;
        #1 reset = 1'b1;
        set_ops(0, 5, 7, 143);
        set_ops(1, 2, 10, 1000);
        @(negedge clk);
        chk("reset_busy", W'(busy), '0);
        chk("reset_owner", W'(owner), '0);
        chk("reset_result", rsp_result, '0);
        @(posedge clk); #2 reset = 1'b0;

        // Single request: start one cycle after req is sampled, 5^7 mod 143 = 47.
        @(posedge clk); #2 req = 2'b01;
        @(negedge clk); chk("start_before_grant", W'(core_start), '0);
        @(negedge clk); chk("start_latency", W'(core_start), W'(1));
        chk("busy_after_grant", W'(busy), W'(1));
        wait_log(1);
        expect_log("single", 0, 0, 47);

        // Simultaneous from reset: 0 first, then 1 (2^10 mod 1000 = 24).
        do_reset();
        n0 = log_owner.size();
        @(posedge clk); #2 req = 2'b11;
        wait_log(n0 + 2);
        expect_log("simul0", n0, 0, 47);
        expect_log("simul1", n0 + 1, 1, 24);

        // Fairness over six back-to-back operations.
        do_reset();
        n0 = log_owner.size();
        @(posedge clk); #2 req = 2'b11;
        wait_log(n0 + 6);
        for (int k = 0; k < 6; k++) begin
            expect_log("fair", n0 + k, k % 2, (k % 2 == 0) ? 47 : 24);
        end

        // Stale done: core_done still high holding 24; new op must return 3^4 mod 100 = 81.
        set_ops(0, 3, 4, 100);
        n0 = log_owner.size();
        @(posedge clk); #2 req = 2'b01;
        wait_log(n0 + 1);
        expect_log("stale", n0, 0, 81);

        // Reset ten cycles into a core operation, then requester 1 alone.
        n0 = log_owner.size();
        @(posedge clk); #2 req = 2'b01;
        for (int k = 0; k < 10 && !core_start; k++) @(negedge clk);
        repeat (10) @(posedge clk);
        #2 reset = 1'b1; req = 2'b00;
        @(negedge clk);
        chk("midreset_busy", W'(busy), '0);
        chk("midreset_valid", W'(rsp_valid), '0);
        chk("midreset_owner", W'(owner), '0);
        chk("midreset_result", rsp_result, '0);
        @(posedge clk); #2 reset = 1'b0;
        repeat (5) @(posedge clk);
        chk("midreset_no_rsp", W'(log_owner.size()), W'(n0));
        #2 req = 2'b10;
        wait_log(n0 + 1);
        expect_log("after_reset", n0, 1, 24);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

endmodule
